// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: sequencing controls, external PC load, memory read port and register views.
// The slave side is the fetch unit; the master side is the control unit plus memory.
interface fetch_unit_if #(
   parameter int unsigned WIDTH = 16
);
   logic             Run;
   logic             Continue;
   logic             Step_Mode;
   logic             LD_PC_EXT;
   logic [WIDTH-1:0] PC_EXT;
   logic [WIDTH-1:0] MEM_RDATA;
   logic             MEM_READY;
   logic             MEM_REQ;
   logic [WIDTH-1:0] MEM_ADDR;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] MAR;
   logic [WIDTH-1:0] MDR;
   logic [WIDTH-1:0] IR;
   logic             IR_VALID;
   logic             BUSY;

   modport master (
      output Run, Continue, Step_Mode, LD_PC_EXT, PC_EXT, MEM_RDATA, MEM_READY,
      input  MEM_REQ, MEM_ADDR, PC, MAR, MDR, IR, IR_VALID, BUSY
   );

   modport slave (
      input  Run, Continue, Step_Mode, LD_PC_EXT, PC_EXT, MEM_RDATA, MEM_READY,
      output MEM_REQ, MEM_ADDR, PC, MAR, MDR, IR, IR_VALID, BUSY
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch datapath (PC/MAR/MDR/IR) with a FETCH1/2/3 sequencer,
// configurable PC stride, external PC load and single-step pause/continue.
module fetch_unit #(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(1)
) (
   input logic         Clk,
   input logic         Reset,
   fetch_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH1 = 3'd1,
      FETCH2 = 3'd2,
      FETCH3 = 3'd3,
      PAUSE  = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] mar_q;
   logic [WIDTH-1:0] mdr_q;
   logic [WIDTH-1:0] ir_q;
   logic             ir_valid_q;
   logic             cont_q;
   logic             cont_rise;

   // A Continue already high when PAUSE is entered must not count as a resume.
   assign cont_rise = bus.Continue & ~cont_q;

   // State register
   always_ff @(posedge Clk) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; Run=0 only takes effect at an instruction boundary
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.Run) state_d = FETCH1;
         FETCH1:  state_d = FETCH2;
         FETCH2:  if (bus.MEM_READY) state_d = FETCH3;
         FETCH3: begin
            if (!bus.Run)          state_d = IDLE;
            else if (bus.Step_Mode) state_d = PAUSE;
            else                    state_d = FETCH1;
         end
         PAUSE: begin
            if (!bus.Run)      state_d = IDLE;
            else if (cont_rise) state_d = FETCH1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus.MEM_REQ = 1'b0;
      bus.BUSY    = 1'b0;
      case (state_q)
         FETCH1:  bus.BUSY = 1'b1;
         FETCH2: begin
            bus.BUSY    = 1'b1;
            bus.MEM_REQ = 1'b1;
         end
         FETCH3:  bus.BUSY = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers; an external PC load beats the FETCH1 increment
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         pc_q       <= PC_RESET;
         mar_q      <= '0;
         mdr_q      <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         cont_q     <= 1'b0;
      end else begin
         cont_q     <= bus.Continue;
         ir_valid_q <= (state_q == FETCH3);
         if (state_q == FETCH1) mar_q <= pc_q;
         if (bus.LD_PC_EXT)          pc_q <= bus.PC_EXT;
         else if (state_q == FETCH1) pc_q <= pc_q + PC_INC;
         if ((state_q == FETCH2) && bus.MEM_READY) mdr_q <= bus.MEM_RDATA;
         if (state_q == FETCH3) ir_q <= mdr_q;
      end
   end

   assign bus.PC       = pc_q;
   assign bus.MAR      = mar_q;
   assign bus.MEM_ADDR = mar_q;
   assign bus.MDR      = mdr_q;
   assign bus.IR       = ir_q;
   assign bus.IR_VALID = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait fetch, wait states, single-step,
// external PC load and PC wrap with reset during FETCH2.
module tb_fetch_unit;

   localparam int unsigned WIDTH = 16;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   fetch_unit_if #(.WIDTH(WIDTH)) bus ();

   fetch_unit #(.WIDTH(WIDTH)) dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] mem_word(input logic [WIDTH-1:0] addr);
      if (addr == 16'h0000)      return 16'h1234;
      else if (addr == 16'h0001) return 16'h5678;
      else                       return addr ^ 16'hA5A5;
   endfunction

   assign bus.MEM_RDATA = mem_word(bus.MEM_ADDR);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b0;
      bus.Run       = 1'b0;
      bus.Continue  = 1'b0;
      bus.Step_Mode = 1'b0;
      bus.LD_PC_EXT = 1'b0;
      bus.PC_EXT    = '0;
      bus.MEM_READY = 1'b0;

      // Reset state
      tick(2);
      reset = 1'b1;
      check_eq("rst_pc", 32'(bus.PC), 32'h0);
      check_eq("rst_ir", 32'(bus.IR), 32'h0);
      check_eq("rst_mar", 32'(bus.MAR), 32'h0);
      check_eq("rst_mdr", 32'(bus.MDR), 32'h0);
      check_eq("rst_req", 32'(bus.MEM_REQ), 32'h0);
      check_eq("rst_busy", 32'(bus.BUSY), 32'h0);
      check_eq("rst_irv", 32'(bus.IR_VALID), 32'h0);

      // Zero-wait fetch of two instructions
      bus.Run = 1'b1;
      bus.MEM_READY = 1'b1;
      tick();
      check_eq("f_e1_busy", 32'(bus.BUSY), 32'h1);
      check_eq("f_e1_req", 32'(bus.MEM_REQ), 32'h0);
      tick();
      check_eq("f_e2_mar", 32'(bus.MAR), 32'h0);
      check_eq("f_e2_pc", 32'(bus.PC), 32'h1);
      check_eq("f_e2_req", 32'(bus.MEM_REQ), 32'h1);
      tick();
      check_eq("f_e3_mdr", 32'(bus.MDR), 32'h1234);
      check_eq("f_e3_irv", 32'(bus.IR_VALID), 32'h0);
      tick();
      check_eq("f_e4_ir", 32'(bus.IR), 32'h1234);
      check_eq("f_e4_irv", 32'(bus.IR_VALID), 32'h1);
      tick(2);
      check_eq("f_e6_mdr", 32'(bus.MDR), 32'h5678);
      bus.Run = 1'b0;
      tick();
      check_eq("f_e7_ir", 32'(bus.IR), 32'h5678);
      check_eq("f_e7_irv", 32'(bus.IR_VALID), 32'h1);
      check_eq("f_e7_pc", 32'(bus.PC), 32'h2);
      check_eq("f_e7_idle", 32'(bus.BUSY), 32'h0);

      // Three FETCH2 wait cycles
      bus.Run = 1'b1;
      bus.MEM_READY = 1'b0;
      tick(2);
      check_eq("w_mar", 32'(bus.MAR), 32'h2);
      check_eq("w_req0", 32'(bus.MEM_REQ), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("w_req", 32'(bus.MEM_REQ), 32'h1);
         check_eq("w_mdr_hold", 32'(bus.MDR), 32'h5678);
      end
      bus.MEM_READY = 1'b1;
      tick();
      check_eq("w_mdr", 32'(bus.MDR), 32'hA5A7);
      check_eq("w_e6_irv", 32'(bus.IR_VALID), 32'h0);
      check_eq("w_e6_req", 32'(bus.MEM_REQ), 32'h0);
      bus.Run = 1'b0;
      tick();
      check_eq("w_e7_irv", 32'(bus.IR_VALID), 32'h1);
      check_eq("w_e7_ir", 32'(bus.IR), 32'hA5A7);
      check_eq("w_e7_idle", 32'(bus.BUSY), 32'h0);

      // Single-step: Continue held high across PAUSE entry must not resume
      bus.Run = 1'b1;
      bus.Step_Mode = 1'b1;
      bus.Continue = 1'b1;
      tick(4);
      check_eq("s_ir", 32'(bus.IR), 32'hA5A6);
      check_eq("s_irv", 32'(bus.IR_VALID), 32'h1);
      check_eq("s_pause", 32'(bus.BUSY), 32'h0);
      tick();
      check_eq("s_hold_busy", 32'(bus.BUSY), 32'h0);
      check_eq("s_hold_irv", 32'(bus.IR_VALID), 32'h0);
      bus.Continue = 1'b0;
      tick();
      check_eq("s_low_busy", 32'(bus.BUSY), 32'h0);
      bus.Continue = 1'b1;
      tick();
      check_eq("s_resume_busy", 32'(bus.BUSY), 32'h1);
      check_eq("s_resume_req", 32'(bus.MEM_REQ), 32'h0);
      tick();
      check_eq("s_mar", 32'(bus.MAR), 32'h4);
      check_eq("s_pc", 32'(bus.PC), 32'h5);
      bus.Step_Mode = 1'b0;
      bus.Continue = 1'b0;
      tick(2);
      check_eq("s_f1_busy", 32'(bus.BUSY), 32'h1);
      check_eq("s_f1_req", 32'(bus.MEM_REQ), 32'h0);

      // External PC load during FETCH1
      bus.LD_PC_EXT = 1'b1;
      bus.PC_EXT = 16'h3000;
      tick();
      check_eq("j_mar", 32'(bus.MAR), 32'h5);
      check_eq("j_pc", 32'(bus.PC), 32'h3000);
      bus.LD_PC_EXT = 1'b0;
      tick(3);
      check_eq("j_mar2", 32'(bus.MAR), 32'h3000);
      check_eq("j_pc2", 32'(bus.PC), 32'h3001);
      bus.Run = 1'b0;
      tick();
      check_eq("j_inflight", 32'(bus.BUSY), 32'h1);
      tick();
      check_eq("j_idle", 32'(bus.BUSY), 32'h0);

      // PC wrap, then reset while waiting in FETCH2
      bus.LD_PC_EXT = 1'b1;
      bus.PC_EXT = 16'hFFFF;
      tick();
      check_eq("x_pc_ld", 32'(bus.PC), 32'hFFFF);
      check_eq("x_idle", 32'(bus.BUSY), 32'h0);
      bus.LD_PC_EXT = 1'b0;
      bus.Run = 1'b1;
      bus.MEM_READY = 1'b0;
      tick(2);
      check_eq("x_wrap_pc", 32'(bus.PC), 32'h0);
      check_eq("x_mar", 32'(bus.MAR), 32'hFFFF);
      check_eq("x_addr", 32'(bus.MEM_ADDR), 32'hFFFF);
      check_eq("x_req", 32'(bus.MEM_REQ), 32'h1);
      reset = 1'b0;
      tick();
      check_eq("x_rst_req", 32'(bus.MEM_REQ), 32'h0);
      check_eq("x_rst_busy", 32'(bus.BUSY), 32'h0);
      check_eq("x_rst_mar", 32'(bus.MAR), 32'h0);
      check_eq("x_rst_pc", 32'(bus.PC), 32'h0);
      reset = 1'b1;
      bus.Run = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
